// File: rtl/pipeline_state_dumper.sv
// Architectural state dumper: streams a cycle stamp, the 32 registers and a
// window of data memory as tagged words over a valid/ready interface.
module pipeline_state_dumper #(
  parameter int          CNT_W     = 32,
  parameter int          MEM_WORDS = 8,
  parameter logic [31:0] MEM_BASE  = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        req_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic [31:0] data_o,
  output logic [7:0]  tag_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o
);
  typedef enum logic [2:0] {IDLE, CYC, REG, MEM, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, snap;
  logic [5:0]       idx;
  logic             last;   // final memory word is loaded, waiting for it to drain
  logic             load, accept;

  assign accept = valid_o && ready_i;
  assign load   = (state == CYC || state == REG || (state == MEM && !last)) &&
                  (!valid_o || ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_i) state_n = CYC;
      CYC:     if (load) state_n = REG;
      REG:     if (load && idx == 6'd31) state_n = MEM;
      MEM:     if (last && accept) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state != IDLE);
    done_o     = (state == DONE);
    reg_addr_o = (state == REG) ? idx[4:0] : 5'd0;
    mem_addr_o = (state == MEM) ? MEM_BASE + {24'b0, idx, 2'b00} : 32'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      snap    <= '0;
      idx     <= '0;
      last    <= 1'b0;
      data_o  <= '0;
      tag_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      if (start_i) cnt <= cnt + CNT_W'(1);
      if (state == IDLE && req_i) snap <= cnt;
      if (load) begin
        valid_o <= 1'b1;
        case (state)
          CYC: begin
            data_o <= 32'(snap);
            tag_o  <= 8'h00;
            idx    <= '0;
          end
          REG: begin
            data_o <= reg_data_i;
            tag_o  <= {2'b01, idx};
            idx    <= (idx == 6'd31) ? 6'd0 : idx + 6'd1;
          end
          MEM: begin
            data_o <= mem_data_i;
            tag_o  <= {2'b10, idx};
            if (idx == 6'(MEM_WORDS - 1)) last <= 1'b1;
            else                          idx  <= idx + 6'd1;
          end
          default: ;
        endcase
      end else if (accept) begin
        valid_o <= 1'b0;
      end
      if (state == DONE) begin
        last <= 1'b0;
        idx  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_state_dumper.sv
// Bench for pipeline_state_dumper: a default instance and a small one (4-bit
// counter, two memory words at 0x10), each fed by array-backed read ports.
module tb_pipeline_state_dumper;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], start[2], req[2], ready[2];
  logic [4:0]  reg_addr[2];
  logic [31:0] reg_data[2], mem_addr[2], mem_data[2], data[2];
  logic [7:0]  tag[2];
  logic        valid[2], busy[2], done[2];

  logic [31:0] regs[32];
  logic [31:0] mem[64];
  int unsigned ref_cnt[2];
  int          checks = 0, failures = 0;
  logic [39:0] dump_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] last_stamp;

  pipeline_state_dumper u_dut (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .req_i(req[0]),
    .reg_addr_o(reg_addr[0]), .reg_data_i(reg_data[0]),
    .mem_addr_o(mem_addr[0]), .mem_data_i(mem_data[0]),
    .data_o(data[0]), .tag_o(tag[0]), .valid_o(valid[0]), .ready_i(ready[0]),
    .busy_o(busy[0]), .done_o(done[0]));

  pipeline_state_dumper #(.CNT_W(4), .MEM_WORDS(2), .MEM_BASE(32'h10)) u_small (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .req_i(req[1]),
    .reg_addr_o(reg_addr[1]), .reg_data_i(reg_data[1]),
    .mem_addr_o(mem_addr[1]), .mem_data_i(mem_data[1]),
    .data_o(data[1]), .tag_o(tag[1]), .valid_o(valid[1]), .ready_i(ready[1]),
    .busy_o(busy[1]), .done_o(done[1]));

  assign reg_data[0] = regs[reg_addr[0]];
  assign reg_data[1] = regs[reg_addr[1]];
  assign mem_data[0] = mem[mem_addr[0][7:2]];
  assign mem_data[1] = mem[mem_addr[1][7:2]];

  // Reference cycle counter: counts running edges since reset.
  always @(posedge clk) begin
    if (rst[0]) ref_cnt[0] <= 0;
    else if (start[0]) ref_cnt[0] <= ref_cnt[0] + 1;
    if (rst[1]) ref_cnt[1] <= 0;
    else if (start[1]) ref_cnt[1] <= (ref_cnt[1] + 1) % 16;
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic randomize_state();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
  endtask

  // Request a dump on instance s (called at a negedge) and check the stream.
  task automatic run_dump(input int s, input bit bp, input bit extra_req, input string name);
    logic [39:0] expq[$];
    int n, mw, mb, dones, first_v, first_b, done_c, idle_c;
    bit pv, pr;
    logic [39:0] pw;
    n = (s == 0) ? 41 : 35;
    mw = (s == 0) ? 8 : 2;
    mb = (s == 0) ? 0 : 4;
    dones = 0; first_v = -1; first_b = -1; done_c = -1; idle_c = -1;
    pv = 1'b0; pr = 1'b0; pw = '0;
    dump_q.delete();
    addr_q.delete();
    expq.push_back({8'h00, 32'(ref_cnt[s])});
    for (int i = 0; i < 32; i++) expq.push_back({8'h40 | 8'(i), regs[i]});
    for (int i = 0; i < mw; i++) expq.push_back({8'h80 | 8'(i), mem[mb+i]});
    for (int c = 0; c < 400; c++) begin
      if (pv && !pr) begin
        checks++;
        if (valid[s] !== 1'b1 || {tag[s], data[s]} !== pw) begin
          failures++;
          $display("FAIL %s stall_hold: got v=%b %h want v=1 %h", name, valid[s], {tag[s], data[s]}, pw);
        end
      end
      if (busy[s] === 1'b1 && first_b < 0) first_b = c;
      if (valid[s] === 1'b1 && first_v < 0) first_v = c;
      if (done[s] === 1'b1) begin
        dones++;
        if (done_c < 0) done_c = c;
      end
      if (s == 1 && mem_addr[s] != 0 && (addr_q.size() == 0 || addr_q[$] != mem_addr[s]))
        addr_q.push_back(mem_addr[s]);
      if (dones > 0 && busy[s] === 1'b0) begin
        idle_c = c;
        break;
      end
      req[s] = (c == 0) || (extra_req && (c == 5 || c == 20 || done[s] === 1'b1));
      ready[s] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid[s] === 1'b1 && ready[s]) dump_q.push_back({tag[s], data[s]});
      pv = valid[s]; pr = ready[s]; pw = {tag[s], data[s]};
      cyc();
    end
    req[s] = 1'b0;
    ready[s] = 1'b1;

    checks++;
    if (idle_c < 0) begin failures++; $display("FAIL %s timeout: dump did not finish in 400 cycles", name); end
    checks++;
    if (dones != 1) begin failures++; $display("FAIL %s done_count: got %0d want 1", name, dones); end
    checks++;
    if (first_b != 1) begin failures++; $display("FAIL %s busy_latency: got %0d want 1", name, first_b); end
    if (!bp) begin
      checks++;
      if (first_v != 2) begin failures++; $display("FAIL %s first_valid: got %0d want 2", name, first_v); end
      checks++;
      if (done_c != n + 2) begin failures++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_c, n + 2); end
      checks++;
      if (idle_c != n + 3) begin failures++; $display("FAIL %s idle_cycle: got %0d want %0d", name, idle_c, n + 3); end
    end
    checks++;
    if (dump_q.size() != n) begin
      failures++;
      $display("FAIL %s word_count: got %0d want %0d", name, dump_q.size(), n);
    end
    for (int i = 0; i < n && i < dump_q.size(); i++) begin
      checks++;
      if (dump_q[i] !== expq[i]) begin
        failures++;
        $display("FAIL %s word[%0d]: got %h want %h", name, i, dump_q[i], expq[i]);
      end
    end
    last_stamp = (dump_q.size() > 0) ? dump_q[0][31:0] : 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (busy[s] !== 1'b0 || valid[s] !== 1'b0) begin
        failures++;
        $display("FAIL %s quiet_after: got busy=%b valid=%b want 0 0", name, busy[s], valid[s]);
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; start[s] = 1'b0; req[s] = 1'b0; ready[s] = 1'b1;
    end
    for (int i = 0; i < 32; i++) regs[i] = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    cyc();
    cyc();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({valid[s], busy[s], done[s], data[s], tag[s], reg_addr[s], mem_addr[s]} !== '0) begin
        failures++;
        $display("FAIL reset_state[%0d]: got v=%b b=%b d=%b data=%h tag=%h ra=%h ma=%h want all 0",
                 s, valid[s], busy[s], done[s], data[s], tag[s], reg_addr[s], mem_addr[s]);
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    start[0] = 1'b1;
  endtask

  task automatic test_basic();
    randomize_state();
    regs[8] = 32'd5;
    regs[9] = 32'hFFFF_FFFF;
    mem[0]  = 32'd5;
    repeat (10) cyc();
    run_dump(0, 1'b0, 1'b0, "basic");
    checks++;
    if (last_stamp !== 32'd10) begin failures++; $display("FAIL basic stamp: got %0d want 10", last_stamp); end
    if (dump_q.size() == 41) begin
      checks++;
      if (dump_q[9] !== {8'h48, 32'd5} || dump_q[10] !== {8'h49, 32'hFFFF_FFFF} || dump_q[33] !== {8'h80, 32'd5}) begin
        failures++;
        $display("FAIL basic preload: got %h %h %h want 4800000005 49ffffffff 8000000005",
                 dump_q[9], dump_q[10], dump_q[33]);
      end
    end
  endtask

  task automatic test_backpressure();
    randomize_state();
    run_dump(0, 1'b1, 1'b0, "backpressure");
    randomize_state();
    run_dump(0, 1'b1, 1'b0, "backpressure2");
  endtask

  task automatic test_req_while_busy();
    randomize_state();
    run_dump(0, 1'b0, 1'b1, "req_busy");
  endtask

  task automatic test_reset_mid_dump();
    bit hit;
    hit = 1'b0;
    randomize_state();
    req[0] = 1'b1; ready[0] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (valid[0] === 1'b1 && tag[0] === 8'h4F) begin hit = 1'b1; break; end
      cyc();
      req[0] = 1'b0;
    end
    req[0] = 1'b0;
    checks++;
    if (!hit) begin failures++; $display("FAIL mid_reset reach_4f: got no tag 4f want tag 4f"); end
    rst[0] = 1'b1;
    cyc();
    rst[0] = 1'b0;
    checks++;
    if ({valid[0], busy[0], done[0], data[0], tag[0]} !== '0) begin
      failures++;
      $display("FAIL mid_reset state: got v=%b b=%b d=%b data=%h tag=%h want all 0",
               valid[0], busy[0], done[0], data[0], tag[0]);
    end
    repeat (3) cyc();
    run_dump(0, 1'b0, 1'b0, "post_reset");
    checks++;
    if (last_stamp !== 32'd3) begin failures++; $display("FAIL post_reset stamp: got %0d want 3", last_stamp); end
  endtask

  task automatic test_counter_wrap();
    randomize_state();
    repeat (5) cyc();
    run_dump(1, 1'b0, 1'b0, "frozen");
    checks++;
    if (last_stamp !== 32'd0) begin failures++; $display("FAIL frozen stamp: got %0d want 0", last_stamp); end
    start[1] = 1'b1;
    repeat (15) cyc();
    start[1] = 1'b0;
    run_dump(1, 1'b0, 1'b0, "pre_wrap");
    checks++;
    if (last_stamp !== 32'd15) begin failures++; $display("FAIL pre_wrap stamp: got %0d want 15", last_stamp); end
    start[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    run_dump(1, 1'b0, 1'b0, "wrap");
    checks++;
    if (last_stamp !== 32'd0) begin failures++; $display("FAIL wrap stamp: got %0d want 0", last_stamp); end
  endtask

  task automatic test_mem_base();
    randomize_state();
    run_dump(1, 1'b1, 1'b0, "mem_base");
    checks++;
    if (addr_q.size() != 2 || addr_q[0] !== 32'h10 || addr_q[1] !== 32'h14) begin
      failures++;
      $display("FAIL mem_base addr_seq: got %0d addrs first=%h want 2 addrs 10 14",
               addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_req_while_busy();
    test_reset_mid_dump();
    test_counter_wrap();
    test_mem_base();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_state_dumper.md
# pipeline_state_dumper

Hardware counterpart to the bench-side state printer. On request it walks the CPU register file and a window of data memory through their read ports and streams a cycle-stamped snapshot out over a valid/ready word interface. It sits inside `CPU`, beside `Registers` and `Data_Memory`, so a host or checker can capture architectural state without hierarchical peeks.

## Interface
- `CNT_W`, 32: width of the free-running cycle counter; the counter is zero-extended to 32 bits when emitted.
- `MEM_WORDS`, 8: number of 32-bit data-memory words per dump (1..64).
- `MEM_BASE`, 0: byte address of the first dumped memory word; must be word-aligned.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: CPU running; the cycle counter increments only while high.
- `req_i` in 1: dump request; sampled only in IDLE.
- `reg_addr_o` out 5: register-file read address.
- `reg_data_i` in 32: register-file read data, combinational from `reg_addr_o`.
- `mem_addr_o` out 32: data-memory byte address, word-aligned.
- `mem_data_i` in 32: data-memory word, combinational from `mem_addr_o`.
- `data_o` out 32: snapshot word.
- `tag_o` out 8: [7:6] kind (0 = cycle, 1 = register, 2 = memory); [5:0] index.
- `valid_o` out 1: `data_o` and `tag_o` hold a word.
- `ready_i` in 1: consumer accepts the word this cycle.
- `busy_o` out 1: dump in progress.
- `done_o` out 1: one-cycle pulse marking the end of a dump.

## Operation
- States: IDLE -> CYC -> REG -> MEM -> DONE -> IDLE.
- Cycle counter:
  - Resets to 0.
  - Increments by 1 on every edge with `start_i`=1 and wraps modulo 2^CNT_W.
  - Runs regardless of dump state.
- IDLE:
  - When `req_i`=1 at an edge, capture the counter value (pre-increment) into the snapshot and go to CYC.
  - In every other state `req_i` is ignored; requests are never queued.
- Output register:
  - Loads when (state in CYC/REG/MEM) and (`valid_o`=0 or `ready_i`=1).
  - A word is accepted at an edge where `valid_o`=1 and `ready_i`=1.
  - `data_o` and `tag_o` are stable while `valid_o`=1 and `ready_i`=0.
- CYC:
  - Loads the snapshot, tag 0x00, then goes to REG with index 0.
- REG:
  - `reg_addr_o` = index.
  - On load, `data_o` = `reg_data_i` and `tag_o` = {2'b01, index}.
  - Index 31 goes to MEM with index 0.
  - R0 is emitted exactly as returned by the port.
- MEM:
  - `mem_addr_o` = MEM_BASE + 4*index.
  - On load, `data_o` = `mem_data_i` and `tag_o` = {2'b10, index}.
  - After index MEM_WORDS-1 is loaded, wait until that word is accepted, then go to DONE.
- DONE: `done_o`=1 for one cycle, then IDLE.
- Addresses: `reg_addr_o` and `mem_addr_o` read 0 outside REG and MEM respectively.
- `busy_o` = 1 in CYC, REG, MEM and DONE.
- Total words per dump: 33 + MEM_WORDS (41 at default).
- Reset in any state, including mid-dump with a pending word:
  - Next cycle: IDLE, counter 0, `valid_o`=0.
  - The partial dump is discarded and is not resumed.

## Timing
- Reset values: `valid_o`=0, `busy_o`=0, `done_o`=0, `data_o`=0, `tag_o`=0, `reg_addr_o`=0, `mem_addr_o`=0.
- Request at edge N:
  - `busy_o`=1 from cycle N+1.
  - First word (cycle stamp) has `valid_o`=1 in cycle N+2.
- With `ready_i` held high: one word per cycle, words k=0..40 valid in cycles N+2..N+42, `done_o` in N+43, `busy_o`=0 from N+44.
- Each cycle of `ready_i`=0 while `valid_o`=1 adds exactly one cycle; no word is dropped or duplicated.
- A new request is accepted no earlier than the edge ending the first IDLE cycle after `done_o`.
- Read ports are sampled at the loading edge only; changes in register or memory contents during a dump appear in words not yet loaded.

## Test plan
- Basic dump:
  - Setup: preload R8=5, R9=0xFFFFFFFF, mem word 0 = 5; `start_i`=1 from cycle 0; `req_i` pulsed at cycle 10; `ready_i`=1.
  - Expect: 41 words; first is tag 0x00 with data 10; tag 0x48 data 5; tag 0x49 data 0xFFFFFFFF; tag 0x80 data 5; `done_o` exactly once.
- Backpressure:
  - Stimulus: toggle `ready_i` pseudo-randomly.
  - Expect: same 41 tag/data pairs in order; output stable while stalled; no loss or duplication.
- Request while busy: extra `req_i` pulses mid-dump and in the DONE cycle -> ignored; exactly one dump and one `done_o`.
- Reset mid-dump:
  - Stimulus: `rst_i` asserted while emitting tag 0x4F.
  - Expect: next cycle `valid_o`=0, `busy_o`=0, counter 0; a fresh request yields a full dump whose cycle word counts from the reset.
- Counter gating and wrap:
  - Setup: CNT_W=4.
  - Expect: `start_i`=0 freezes the stamp value; after 16 running cycles the stamp wraps 15 -> 0.
- MEM_BASE=0x10, MEM_WORDS=2: `mem_addr_o` sequence 0x10, 0x14; tags 0x80, 0x81; 35 words total.
